// File: rtl/spifi_arb_pkg.sv
// Shared types for the two-master AHB arbiter: htrans codes, master index,
// and the address/control bundle that the holding registers store.
package spifi_arb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } mst_e;

    typedef struct packed {
        logic [31:0] haddr;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic [3:0]  hprot;
        logic [1:0]  htrans;
        logic        hmastlock;
    } ahb_ctrl_t;

    localparam int CTRL_W = $bits(ahb_ctrl_t);

    // The address-phase owner may not be switched away while it is inside a
    // burst or holding the bus lock.
    function automatic logic in_burst(input logic [1:0] htrans, input logic lock);
        return (htrans == HTRANS_SEQ) || (htrans == HTRANS_BUSY) || lock;
    endfunction

endpackage

// File: rtl/spifi_arb_hold.sv
// Per-master holding register: parks an address phase the slave has not yet
// taken, and raises pending until the arbiter presents and retires it.
module spifi_arb_hold
    import spifi_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_capture,
    input  logic              i_accept,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_pending,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              pend_q, pend_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    always_comb begin
        pend_d = pend_q;
        ctrl_d = ctrl_q;
        if (i_accept) begin
            pend_d = 1'b0;
        end else if (i_capture) begin
            pend_d = 1'b1;
            ctrl_d = i_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            ctrl_q <= '0;
        end else begin
            pend_q <= pend_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign o_pending = pend_q;
    assign o_ctrl    = ctrl_q;

endmodule

// File: rtl/spifi_mem_arb.sv
// Two-master to one-slave AHB-Lite arbiter in front of the SPIFI memory port;
// combinational grant so an uncontended master sees no added latency.
module spifi_mem_arb
    import spifi_arb_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic        i_hclk,
    input  logic        i_hreset,
    input  logic        i_hsel_m0,
    input  logic [31:0] i_haddr_m0,
    input  logic        i_hwrite_m0,
    input  logic [2:0]  i_hsize_m0,
    input  logic [2:0]  i_hburst_m0,
    input  logic [3:0]  i_hprot_m0,
    input  logic [1:0]  i_htrans_m0,
    input  logic        i_hmastlock_m0,
    input  logic        i_hready_m0,
    input  logic [31:0] i_hwdata_m0,
    output logic        o_hready_m0,
    output logic        o_hresp_m0,
    output logic [31:0] o_hrdata_m0,
    input  logic        i_hsel_m1,
    input  logic [31:0] i_haddr_m1,
    input  logic        i_hwrite_m1,
    input  logic [2:0]  i_hsize_m1,
    input  logic [2:0]  i_hburst_m1,
    input  logic [3:0]  i_hprot_m1,
    input  logic [1:0]  i_htrans_m1,
    input  logic        i_hmastlock_m1,
    input  logic        i_hready_m1,
    input  logic [31:0] i_hwdata_m1,
    output logic        o_hready_m1,
    output logic        o_hresp_m1,
    output logic [31:0] o_hrdata_m1,
    output logic        o_hsel_sl,
    output logic [31:0] o_haddr_sl,
    output logic        o_hwrite_sl,
    output logic [2:0]  o_hsize_sl,
    output logic [2:0]  o_hburst_sl,
    output logic [3:0]  o_hprot_sl,
    output logic [1:0]  o_htrans_sl,
    output logic        o_hmastlock_sl,
    output logic        o_hready_i_sl,
    output logic [31:0] o_hwdata_sl,
    input  logic        i_hready_o_sl,
    input  logic        i_hresp_sl,
    input  logic [31:0] i_hrdata_sl
);

    ahb_ctrl_t [1:0]             live, eff;
    logic      [1:0][CTRL_W-1:0] held;
    logic      [1:0]             hsel, hready_m, valid, pend, req;
    logic      [1:0]             capture, accept, gnt_oh, own_oh;
    mst_e                        gnt_q, gnt_d, last_q, last_d, dp_own_q, dp_own_d;
    logic                        dp_act_q, dp_act_d, arb_free, sl_act;
    ahb_ctrl_t                   ctrl_sl;

    assign hsel     = {i_hsel_m1, i_hsel_m0};
    assign hready_m = {i_hready_m1, i_hready_m0};

    always_comb begin
        live[0].haddr     = i_haddr_m0;
        live[0].hwrite    = i_hwrite_m0;
        live[0].hsize     = i_hsize_m0;
        live[0].hburst    = i_hburst_m0;
        live[0].hprot     = i_hprot_m0;
        live[0].htrans    = i_htrans_m0;
        live[0].hmastlock = i_hmastlock_m0;
        live[1].haddr     = i_haddr_m1;
        live[1].hwrite    = i_hwrite_m1;
        live[1].hsize     = i_hsize_m1;
        live[1].hburst    = i_hburst_m1;
        live[1].hprot     = i_hprot_m1;
        live[1].htrans    = i_htrans_m1;
        live[1].hmastlock = i_hmastlock_m1;
        for (int m = 0; m < 2; m++) begin
            eff[m]   = pend[m] ? ahb_ctrl_t'(held[m]) : live[m];
            valid[m] = hsel[m] & live[m].htrans[1] & hready_m[m];
        end
    end

    assign req = pend | valid;

    // A parked request always wins over the live bus of the same master,
    // because that master has already moved on to its data phase.
    assign arb_free = i_hready_o_sl
                    & ~((pend[gnt_q] | hsel[gnt_q])
                        & in_burst(eff[gnt_q].htrans, eff[gnt_q].hmastlock));

    always_comb begin
        gnt_d  = gnt_q;
        last_d = last_q;
        if (arb_free && (req != 2'b00)) begin
            if (req == 2'b11) begin
                gnt_d = ((RR_EN != 0) && (last_q == MST_M0)) ? MST_M1 : MST_M0;
            end else begin
                gnt_d = req[1] ? MST_M1 : MST_M0;
            end
            last_d = gnt_d;
        end
    end

    assign gnt_oh  = {gnt_d == MST_M1, gnt_d == MST_M0};
    // A granted master is parked too if the slave stalls, since its own
    // HREADY may already have let it advance.
    assign capture = valid & ~pend & ~(gnt_oh & {2{i_hready_o_sl}});
    assign accept  = pend & gnt_oh & {2{i_hready_o_sl}};

    for (genvar m = 0; m < 2; m++) begin : g_hold
        spifi_arb_hold u_hold (
            .clk       (i_hclk),
            .rst       (i_hreset),
            .i_capture (capture[m]),
            .i_accept  (accept[m]),
            .i_ctrl    (live[m]),
            .o_pending (pend[m]),
            .o_ctrl    (held[m])
        );
    end

    always_comb begin
        ctrl_sl = eff[gnt_d];
        sl_act  = ~i_hreset
                & (pend[gnt_d] | (hsel[gnt_d] & (ctrl_sl.htrans != HTRANS_IDLE)));
    end

    assign o_hsel_sl      = sl_act;
    assign o_htrans_sl    = sl_act ? ctrl_sl.htrans : HTRANS_IDLE;
    assign o_haddr_sl     = ctrl_sl.haddr;
    assign o_hwrite_sl    = ctrl_sl.hwrite;
    assign o_hsize_sl     = ctrl_sl.hsize;
    assign o_hburst_sl    = ctrl_sl.hburst;
    assign o_hprot_sl     = ctrl_sl.hprot;
    assign o_hmastlock_sl = ctrl_sl.hmastlock;
    assign o_hready_i_sl  = i_hready_o_sl;

    always_comb begin
        dp_own_d = dp_own_q;
        dp_act_d = dp_act_q;
        if (i_hready_o_sl) begin
            dp_own_d = gnt_d;
            dp_act_d = o_hsel_sl & o_htrans_sl[1];
        end
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            gnt_q    <= MST_M0;
            last_q   <= MST_M1;
            dp_own_q <= MST_M0;
            dp_act_q <= 1'b0;
        end else begin
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            dp_own_q <= dp_own_d;
            dp_act_q <= dp_act_d;
        end
    end

    assign own_oh      = {dp_own_q == MST_M1, dp_own_q == MST_M0} & {2{dp_act_q}};
    assign o_hwdata_sl = (dp_own_q == MST_M1) ? i_hwdata_m1 : i_hwdata_m0;

    assign o_hready_m0 = own_oh[0] ? i_hready_o_sl : ~pend[0];
    assign o_hresp_m0  = own_oh[0] & i_hresp_sl;
    assign o_hrdata_m0 = i_hrdata_sl;
    assign o_hready_m1 = own_oh[1] ? i_hready_o_sl : ~pend[1];
    assign o_hresp_m1  = own_oh[1] & i_hresp_sl;
    assign o_hrdata_m1 = i_hrdata_sl;

endmodule

// File: tb/tb_spifi_mem_arb.sv
// Directed bench: instance 0 is round-robin, instance 1 fixed-priority; both
// share the master/slave stimulus and loop each master HREADY back.
module tb_spifi_mem_arb;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel0, sel1, wr0, wr1, lk0, lk1, hready_o, hresp_sl;
    logic [31:0] a0, a1, wd0, wd1, rdata;
    logic [2:0]  sz0, sz1, bu0, bu1;
    logic [3:0]  pr0, pr1;
    logic [1:0]  tr0, tr1;

    logic [1:0]  hsel_sl, hwrite_sl, mlock_sl, hready_i_sl;
    logic [1:0]  hready_m0, hready_m1, hresp_m0, hresp_m1;
    logic [31:0] haddr_sl [2];
    logic [31:0] hwdata_sl [2];
    logic [31:0] hrdata_m0 [2];
    logic [31:0] hrdata_m1 [2];
    logic [2:0]  hsize_sl [2];
    logic [2:0]  hburst_sl [2];
    logic [3:0]  hprot_sl [2];
    logic [1:0]  htrans_sl [2];

    int n_chk  = 0;
    int n_pass = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spifi_mem_arb #(.RR_EN(g == 0 ? 1 : 0)) u_dut (
            .i_hclk(clk), .i_hreset(rst),
            .i_hsel_m0(sel0), .i_haddr_m0(a0), .i_hwrite_m0(wr0), .i_hsize_m0(sz0),
            .i_hburst_m0(bu0), .i_hprot_m0(pr0), .i_htrans_m0(tr0), .i_hmastlock_m0(lk0),
            .i_hready_m0(hready_m0[g]), .i_hwdata_m0(wd0),
            .o_hready_m0(hready_m0[g]), .o_hresp_m0(hresp_m0[g]), .o_hrdata_m0(hrdata_m0[g]),
            .i_hsel_m1(sel1), .i_haddr_m1(a1), .i_hwrite_m1(wr1), .i_hsize_m1(sz1),
            .i_hburst_m1(bu1), .i_hprot_m1(pr1), .i_htrans_m1(tr1), .i_hmastlock_m1(lk1),
            .i_hready_m1(hready_m1[g]), .i_hwdata_m1(wd1),
            .o_hready_m1(hready_m1[g]), .o_hresp_m1(hresp_m1[g]), .o_hrdata_m1(hrdata_m1[g]),
            .o_hsel_sl(hsel_sl[g]), .o_haddr_sl(haddr_sl[g]), .o_hwrite_sl(hwrite_sl[g]),
            .o_hsize_sl(hsize_sl[g]), .o_hburst_sl(hburst_sl[g]), .o_hprot_sl(hprot_sl[g]),
            .o_htrans_sl(htrans_sl[g]), .o_hmastlock_sl(mlock_sl[g]),
            .o_hready_i_sl(hready_i_sl[g]), .o_hwdata_sl(hwdata_sl[g]),
            .i_hready_o_sl(hready_o), .i_hresp_sl(hresp_sl), .i_hrdata_sl(rdata)
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic drv0(input logic s, input logic [1:0] t, input logic [31:0] a,
                        input logic w, input logic l);
        sel0 = s; tr0 = t; a0 = a; wr0 = w; lk0 = l;
    endtask

    task automatic drv1(input logic s, input logic [1:0] t, input logic [31:0] a,
                        input logic w, input logic l);
        sel1 = s; tr1 = t; a1 = a; wr1 = w; lk1 = l;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk({tag, "_htrans"}, 32'(htrans_sl[g]), 0);
            chk({tag, "_hsel"}, 32'(hsel_sl[g]), 0);
            chk({tag, "_hready_m0"}, 32'(hready_m0[g]), 1);
            chk({tag, "_hready_m1"}, 32'(hready_m1[g]), 1);
            chk({tag, "_hresp_m0"}, 32'(hresp_m0[g]), 0);
            chk({tag, "_hresp_m1"}, 32'(hresp_m1[g]), 0);
        end
    endtask

    initial begin
        drv0(0, ID, 0, 0, 0); drv1(0, ID, 0, 0, 0);
        sz0 = 3'd2; sz1 = 3'd2; bu0 = 3'd0; bu1 = 3'd0; pr0 = 4'h3; pr1 = 4'h3;
        wd0 = 32'h0; wd1 = 32'h0; rdata = 32'h0; hready_o = 1'b1; hresp_sl = 1'b0;
        #3;
        chk_reset_outs("rst");
        step();
        rst = 1'b0;

        // single uncontended read by m0
        drv0(1, NS, 32'h0000_0100, 0, 0);
        #2;
        for (int g = 0; g < 2; g++) begin
            chk("single_htrans", 32'(htrans_sl[g]), 32'(NS));
            chk("single_haddr", haddr_sl[g], 32'h100);
            chk("single_hsize", 32'(hsize_sl[g]), 2);
            chk("single_hburst", 32'(hburst_sl[g]), 0);
            chk("single_hprot", 32'(hprot_sl[g]), 3);
            chk("single_hwrite", 32'(hwrite_sl[g]), 0);
            chk("single_mlock", 32'(mlock_sl[g]), 0);
            chk("single_hready_i", 32'(hready_i_sl[g]), 1);
        end
        step();
        drv0(0, ID, 0, 0, 0); rdata = 32'hCAFE_0001;
        #2;
        for (int g = 0; g < 2; g++) begin
            chk("single_dp_hready_m0", 32'(hready_m0[g]), 1);
            chk("single_hrdata_m0", hrdata_m0[g], 32'hCAFE_0001);
            chk("single_hrdata_m1", hrdata_m1[g], 32'hCAFE_0001);
        end
        chk("single_idle_after", 32'(htrans_sl[0]), 32'(ID));
        step();

        // simultaneous NONSEQ, last grant m0
        drv0(1, NS, 32'h100, 0, 0); drv1(1, NS, 32'h200, 1, 0); wd1 = 32'h2222_0000;
        #2;
        chk("tie_rr_haddr", haddr_sl[0], 32'h200);
        chk("tie_rr_hwrite", 32'(hwrite_sl[0]), 1);
        chk("tie_fp_haddr", haddr_sl[1], 32'h100);
        chk("tie_rr_hready_m0", 32'(hready_m0[0]), 1);
        step();
        drv0(0, ID, 0, 0, 0); drv1(0, ID, 0, 0, 0);
        #2;
        chk("tie_rr_haddr2", haddr_sl[0], 32'h100);
        chk("tie_rr_htrans2", 32'(htrans_sl[0]), 32'(NS));
        chk("tie_rr_hwrite2", 32'(hwrite_sl[0]), 0);
        chk("tie_rr_hready_m0_wait", 32'(hready_m0[0]), 0);
        chk("tie_rr_hready_m1", 32'(hready_m1[0]), 1);
        chk("tie_rr_hwdata", hwdata_sl[0], 32'h2222_0000);
        chk("tie_fp_haddr2", haddr_sl[1], 32'h200);
        chk("tie_fp_hready_m1_wait", 32'(hready_m1[1]), 0);
        step();
        rdata = 32'hCAFE_0002;
        #2;
        chk("tie_rr_hready_m0_done", 32'(hready_m0[0]), 1);
        chk("tie_rr_hrdata_m0", hrdata_m0[0], 32'hCAFE_0002);
        chk("tie_rr_idle", 32'(htrans_sl[0]), 32'(ID));
        chk("tie_fp_hready_m1_done", 32'(hready_m1[1]), 1);
        chk("tie_fp_hwdata", hwdata_sl[1], 32'h2222_0000);
        step();

        // m0 INCR4 with m1 arriving at beat 2
        bu0 = 3'b011;
        drv0(1, NS, 32'h1000, 0, 0);
        #2; chk("burst_b1", haddr_sl[0], 32'h1000);
        step();
        drv0(1, SQ, 32'h1004, 0, 0); drv1(1, NS, 32'h2000, 0, 0);
        #2;
        chk("burst_b2", haddr_sl[0], 32'h1004);
        chk("burst_m1_capt_hready", 32'(hready_m1[0]), 1);
        step();
        drv0(1, SQ, 32'h1008, 0, 0); drv1(0, ID, 0, 0, 0);
        #2;
        chk("burst_b3", haddr_sl[0], 32'h1008);
        chk("burst_m1_wait_b3", 32'(hready_m1[0]), 0);
        step();
        drv0(1, SQ, 32'h100C, 0, 0);
        #2;
        chk("burst_b4", haddr_sl[0], 32'h100C);
        chk("burst_m1_wait_b4", 32'(hready_m1[0]), 0);
        step();
        drv0(0, ID, 0, 0, 0);
        #2;
        chk("burst_m1_haddr", haddr_sl[0], 32'h2000);
        chk("burst_m1_htrans", 32'(htrans_sl[0]), 32'(NS));
        chk("burst_m1_wait_last", 32'(hready_m1[0]), 0);
        chk("burst_m0_b4_data", 32'(hready_m0[0]), 1);
        step();
        #2;
        chk("burst_m1_done", 32'(hready_m1[0]), 1);
        chk("burst_idle", 32'(htrans_sl[0]), 32'(ID));
        step();

        // m1 locked read-write pair, m0 requests during the lock
        bu0 = 3'b000;
        drv1(1, NS, 32'h300, 0, 1);
        #2;
        for (int g = 0; g < 2; g++) begin
            chk("lock_rd_haddr", haddr_sl[g], 32'h300);
            chk("lock_rd_mlock", 32'(mlock_sl[g]), 1);
        end
        step();
        drv1(1, NS, 32'h304, 1, 1); wd1 = 32'h3333_0000; drv0(1, NS, 32'h400, 0, 0);
        #2;
        for (int g = 0; g < 2; g++) begin
            chk("lock_wr_haddr", haddr_sl[g], 32'h304);
            chk("lock_m0_capt_hready", 32'(hready_m0[g]), 1);
        end
        step();
        drv1(0, ID, 0, 0, 0); drv0(0, ID, 0, 0, 0);
        #2;
        for (int g = 0; g < 2; g++) begin
            chk("lock_m0_haddr", haddr_sl[g], 32'h400);
            chk("lock_m0_wait", 32'(hready_m0[g]), 0);
            chk("lock_wr_hwdata", hwdata_sl[g], 32'h3333_0000);
        end
        step();
        #2;
        for (int g = 0; g < 2; g++) chk("lock_m0_done", 32'(hready_m0[g]), 1);
        step();

        // ERROR response on beat 2 of an m0 INCR4, m1 pending behind it
        bu0 = 3'b011;
        drv0(1, NS, 32'h1000, 0, 0);
        step();
        drv0(1, SQ, 32'h1004, 0, 0); drv1(1, NS, 32'h5000, 0, 0);
        step();
        drv0(1, SQ, 32'h1008, 0, 0); drv1(0, ID, 0, 0, 0); hready_o = 1'b0; hresp_sl = 1'b1;
        #2;
        chk("err1_hresp_m0", 32'(hresp_m0[0]), 1);
        chk("err1_hready_m0", 32'(hready_m0[0]), 0);
        chk("err1_hready_i", 32'(hready_i_sl[0]), 0);
        chk("err1_hready_m1", 32'(hready_m1[0]), 0);
        step();
        drv0(0, ID, 0, 0, 0); hready_o = 1'b1;
        #2;
        chk("err2_hresp_m0", 32'(hresp_m0[0]), 1);
        chk("err2_hready_m0", 32'(hready_m0[0]), 1);
        chk("err2_m1_haddr", haddr_sl[0], 32'h5000);
        chk("err2_m1_htrans", 32'(htrans_sl[0]), 32'(NS));
        step();
        hresp_sl = 1'b0; bu0 = 3'b000;
        #2;
        chk("err_after_hresp_m0", 32'(hresp_m0[0]), 0);
        chk("err_m1_done", 32'(hready_m1[0]), 1);
        chk("err_m1_hresp", 32'(hresp_m1[0]), 0);
        step();

        // reset while m1 is pending
        drv0(1, NS, 32'h600, 0, 0); drv1(1, NS, 32'h700, 0, 0);
        #2; chk("rstp_m0_first", haddr_sl[0], 32'h600);
        step();
        drv0(0, ID, 0, 0, 0); drv1(0, ID, 0, 0, 0);
        #2; chk("rstp_m1_pending", 32'(hready_m1[0]), 0);
        rst = 1'b1;
        #1;
        chk_reset_outs("rstp");
        step();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #2;
            chk("rstp_no_replay_htrans", 32'(htrans_sl[0]), 32'(ID));
            chk("rstp_no_replay_hsel", 32'(hsel_sl[0]), 0);
            chk("rstp_hready_m1", 32'(hready_m1[0]), 1);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spifi_mem_arb.md
SPIFI_MEM_ARB -- requirements
Module: spifi_mem_arb

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority with m0 highest.
REQ-002 SHALL have port i_hclk, input, 1: sole clock; all state on its rising edge.
REQ-003 SHALL have port i_hreset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have ports i_hsel_m0/m1, input, 1: master select; and o_hsel_sl, output, 1: slave select.
REQ-005 SHALL have ports i_haddr_m0/m1, input, 32: address; and o_haddr_sl, output, 32.
REQ-006 SHALL have ports i_hwrite_m0/m1, input, 1: write; and o_hwrite_sl, output, 1.
REQ-007 SHALL have ports i_hsize_m0/m1 and i_hburst_m0/m1, input, 3 each; and o_hsize_sl, o_hburst_sl, output, 3 each.
REQ-008 SHALL have ports i_hprot_m0/m1, input, 4; and o_hprot_sl, output, 4.
REQ-009 SHALL have ports i_htrans_m0/m1, input, 2; and o_htrans_sl, output, 2.
REQ-010 SHALL have ports i_hmastlock_m0/m1, input, 1; and o_hmastlock_sl, output, 1.
REQ-011 SHALL have ports i_hready_m0/m1, input, 1: bus HREADY; and o_hready_i_sl, output, 1.
REQ-012 SHALL have ports i_hwdata_m0/m1, input, 32; and o_hwdata_sl, output, 32.
REQ-013 SHALL have ports o_hready_m0/m1, output, 1; o_hresp_m0/m1, output, 1; and o_hrdata_m0/m1, output, 32: per-master response.
REQ-014 SHALL have ports i_hready_o_sl, input, 1; i_hresp_sl, input, 1; and i_hrdata_sl, input, 32: slave response.

Function
REQ-015 SHALL treat a master request as valid when hsel & htrans[1] & hready_m.
REQ-016 SHALL capture a valid request that is not granted in that cycle into that master's holding register; it is then pending and o_hready_mN = 0.
REQ-017 SHALL arbitrate only when i_hready_o_sl = 1 and the address-phase owner is not mid-burst: htrans = SEQ or BUSY, or hmastlock = 1.
REQ-018 SHALL, with RR_EN = 1, on a tie grant the master not granted last; with RR_EN = 0, m0 wins every tie.
REQ-019 SHALL drive the slave address/control from the granted master's holding register if pending, else from its live bus; it SHALL clear pending when that phase is accepted (i_hready_o_sl = 1).
REQ-020 SHALL drive o_htrans_sl = IDLE and o_hsel_sl = 0 when no master requests; o_hready_i_sl = i_hready_o_sl.
REQ-021 SHALL register the data-phase owner and its activity flag on each cycle with i_hready_o_sl = 1.
REQ-022 SHALL select o_hwdata_sl from the data-phase owner.
REQ-023 SHALL drive o_hrdata_mN = i_hrdata_sl for both masters.
REQ-024 SHALL drive, per master: if active data-phase owner, o_hready = i_hready_o_sl and o_hresp = i_hresp_sl; else if pending, o_hready = 0 and o_hresp = 0; else o_hready = 1 and o_hresp = 0.
REQ-025 SHALL add zero latency for an uncontended granted master.
REQ-026 SHALL add, for a contended master, wait states equal to the other master's remaining transfers plus 1.
REQ-027 SHALL forward the two-cycle ERROR response to the owner; if the owner then drives IDLE, the burst ends and arbitration is free that cycle.
REQ-028 SHALL make a locked sequence (hmastlock = 1) non-preemptible until its first non-locked address phase.

Reset
REQ-029 SHALL, while i_hreset = 1, clear holding registers, pending flags, grant (m0), last-grant (m1), data-phase owner (none); outputs: o_htrans_sl = IDLE, o_hsel_sl = 0, o_hready_m0/m1 = 1, o_hresp_m0/m1 = 0.
REQ-030 SHALL, on reset mid-transfer, discard the transfer with no replay after release.

Structure
REQ-031 SHALL place htrans encodings (IDLE/BUSY/NONSEQ/SEQ) and the master-index type in package spifi_arb_pkg.
REQ-032 SHALL implement the holding register plus pending flag as sub-module spifi_arb_hold, instantiated once per master.

Verification
REQ-033 m0 single read 0x0000_0100, m1 idle -> slave sees NONSEQ the same cycle; o_hrdata_m0 = slave data; no added wait.
REQ-034 m0 and m1 NONSEQ in the same cycle, RR_EN = 1, last grant m0 -> m1 first, m0 held one extra data phase; slave address order 0x200 then 0x100.
REQ-035 m0 INCR4 at 0x1000 in progress, m1 request at beat 2 -> m1 granted only after beat 4 (0x100C) is accepted.
REQ-036 m1 locked read-write pair with m0 requesting -> m0 waits until m1 unlocks; RR_EN = 0 still does not preempt.
REQ-037 slave ERROR on m0 beat 2 of INCR4, m0 then IDLE -> o_hresp_m0 = 1 for two cycles; m1 pending granted in the next cycle.
REQ-038 i_hreset pulsed during m1 pending -> all outputs return to reset values; no stale transfer on the slave after release.
